busca_menor_10bit: RTL and testbench
====================================

# busca_menor_10bit

Sequential minimum finder that sits directly upstream of the 10-bit unsigned less-than comparator. It consumes a frame of `N_AMOSTRAS` 10-bit unsigned samples through a valid/ready handshake. Each accepted sample is compared against the running minimum using that comparator. At frame end it reports the smallest value and the index of its first occurrence, with a one-cycle completion pulse.

## Interface

- `N_AMOSTRAS`, 8: samples per frame; legal range 2..16.
- `LARGURA_IDX`, 3: width of the index and sample counter; must satisfy 2^`LARGURA_IDX` >= `N_AMOSTRAS`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  start request; sampled only in OCIOSO.
- `valido`  in  1  input sample valid.
- `dado`  in  10  input sample, unsigned.
- `pronto`  out  1  block accepts a sample this cycle; equals (estado == COLETA).
- `menor_valor`  out  10  running/final minimum.
- `indice`  out  `LARGURA_IDX`  position within the frame (0-based) of the first occurrence of the minimum.
- `ocupado`  out  1  high in COLETA and FIM.
- `concluido`  out  1  one-cycle pulse; results are final.

## Operation

- **States.** OCIOSO, COLETA, FIM. Internal counter `contador` has width `LARGURA_IDX`.
- **Reset.** Applies on any edge where `reset`=1, in every state and mid-frame. Afterwards: estado=OCIOSO, `menor_valor`=10'h3FF, `indice`=0, `contador`=0, `concluido`=0, `ocupado`=0, `pronto`=0. An aborted frame produces no `concluido`.
- **OCIOSO.**
  - `iniciar`=1 causes: estado<=COLETA, `menor_valor`<=10'h3FF, `indice`<=0, `contador`<=0.
  - `valido` is ignored.
  - `menor_valor`/`indice` hold the previous frame's results until `iniciar` is accepted.
- **COLETA.** A sample is accepted on an edge where `valido`=1 (`pronto` is 1 throughout). For each accepted sample:
  - If `dado` < `menor_valor` (strict unsigned compare): `menor_valor`<=`dado` and `indice`<=`contador`.
  - Ties do not update, so the first occurrence wins.
  - If `contador` == `N_AMOSTRAS`-1: estado<=FIM. Otherwise `contador`<=`contador`+1.
  - Cycles with `valido`=0 change nothing; gaps of any length are legal.
  - `iniciar` is ignored.
- **FIM.**
  - `concluido`=1 for exactly this one cycle, then estado<=OCIOSO unconditionally.
  - `iniciar` and `valido` are ignored in FIM. A start request must be held or reasserted in OCIOSO.
- **All-0x3FF frame.** No update ever occurs, so the result is `menor_valor`=1023, `indice`=0. This is correct by construction.
- **Arithmetic.** Compare is 10-bit unsigned only. No wrap is possible on `contador`, because it stops at `N_AMOSTRAS`-1.

## Timing

- `pronto`, `ocupado` and `concluido` are decoded from the registered state. They do not depend combinationally on `iniciar`, `valido` or `dado`.
- `iniciar` is sampled at edge t0, and `pronto`=1 from cycle t0+1.
- The last sample is accepted at edge tk. In cycle tk+1, `concluido`=1 and `menor_valor`/`indice` are final. From cycle tk+2, the block is in OCIOSO.
- Minimum frame time is `N_AMOSTRAS`+2 cycles from `iniciar` to return to OCIOSO, with no `valido` gaps.
- `menor_valor`/`indice` update one edge after each accepted sample. They are meaningful only when `concluido`=1 or in OCIOSO.

## Test plan

- **Reset.** Assert `reset` for 2 cycles with random inputs -> `menor_valor`=1023, `indice`=0, `pronto`=`ocupado`=`concluido`=0.
- **Nominal frame.** Pulse `iniciar`, then feed 500,300,700,300,1023,12,12,900 back-to-back -> one cycle after the 8th accept: `concluido`=1, `menor_valor`=12, `indice`=5. Next cycle `ocupado`=0, and results are held.
- **Saturated frame and zero value.**
  - Frame of eight 1023s -> `menor_valor`=1023, `indice`=0.
  - Frame 9,8,7,6,5,4,3,0 -> 0, `indice`=7.
- **Handshake gaps.** Same data as the nominal frame with `valido` low for 1–3 random cycles between samples -> identical result. `concluido` occurs exactly one cycle after the 8th accepted sample.
- **Reset mid-frame.** `reset` after 3 accepted samples -> OCIOSO, no `concluido`, outputs at reset values. A following frame 40,41,...,47 gives `menor_valor`=40, `indice`=0.
- **Ignored controls.**
  - `valido` pulses in OCIOSO cause no state change.
  - `iniciar` pulses during COLETA do not restart the count.
  - `iniciar` held during the FIM cycle is ignored, and the new frame starts only after `iniciar` is seen in OCIOSO.

Source files
------------

// File: rtl/busca_menor_10bit.sv
// Sequential minimum finder: scans a frame of N_AMOSTRAS unsigned 10-bit samples
// and reports the smallest value and the index of its first occurrence.
module busca_menor_10bit #(
   parameter int N_AMOSTRAS  = 8,
   parameter int LARGURA_IDX = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   iniciar,
   input  logic                   valido,
   input  logic [9:0]             dado,
   output logic                   pronto,
   output logic [9:0]             menor_valor,
   output logic [LARGURA_IDX-1:0] indice,
   output logic                   ocupado,
   output logic                   concluido
);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      COLETA = 2'd1,
      FIM    = 2'd2
   } estado_t;

   localparam logic [LARGURA_IDX-1:0] ULTIMO = LARGURA_IDX'(N_AMOSTRAS - 1);

   estado_t                estado_q;
   logic [9:0]             menor_q;
   logic [LARGURA_IDX-1:0] indice_q;
   logic [LARGURA_IDX-1:0] contador_q;
   logic                   amostra_menor;

   // Strict compare: ties keep the earlier index.
   assign amostra_menor = (dado < menor_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         menor_q    <= 10'h3FF;
         indice_q   <= '0;
         contador_q <= '0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (iniciar) begin
                  estado_q   <= COLETA;
                  menor_q    <= 10'h3FF;
                  indice_q   <= '0;
                  contador_q <= '0;
               end
            end
            COLETA: begin
               if (valido) begin
                  if (amostra_menor) begin
                     menor_q  <= dado;
                     indice_q <= contador_q;
                  end
                  if (contador_q == ULTIMO) begin
                     estado_q <= FIM;
                  end else begin
                     contador_q <= contador_q + 1'b1;
                  end
               end
            end
            FIM: begin
               estado_q <= OCIOSO;
            end
            default: begin
               estado_q <= OCIOSO;
            end
         endcase
      end
   end

   // Status flags are pure decodes of the registered state.
   assign pronto      = (estado_q == COLETA);
   assign ocupado     = (estado_q == COLETA) || (estado_q == FIM);
   assign concluido   = (estado_q == FIM);
   assign menor_valor = menor_q;
   assign indice      = indice_q;

endmodule

// File: tb/tb_busca_menor_10bit.sv
// Directed, table-driven bench for busca_menor_10bit with hand-computed results
// and a few hand-written multi-cycle corner-case sequences.
module tb_busca_menor_10bit;

   logic       clk = 1'b0;
   logic       reset;
   logic       iniciar;
   logic       valido;
   logic [9:0] dado;
   logic       pronto;
   logic [9:0] menor_valor;
   logic [2:0] indice;
   logic       ocupado;
   logic       concluido;

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [7:0][9:0] amostra;
      logic [9:0]      exp_min;
      logic [2:0]      exp_idx;
   } quadro_t;

   quadro_t tabela [5];

   busca_menor_10bit #(.N_AMOSTRAS(8), .LARGURA_IDX(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .iniciar     (iniciar),
      .valido      (valido),
      .dado        (dado),
      .pronto      (pronto),
      .menor_valor (menor_valor),
      .indice      (indice),
      .ocupado     (ocupado),
      .concluido   (concluido)
   );

   always #5 clk = ~clk;

   function automatic quadro_t mk(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6, input int a7,
                                  input int m, input int ix);
      quadro_t q;
      q.amostra[0] = 10'(a0); q.amostra[1] = 10'(a1);
      q.amostra[2] = 10'(a2); q.amostra[3] = 10'(a3);
      q.amostra[4] = 10'(a4); q.amostra[5] = 10'(a5);
      q.amostra[6] = 10'(a6); q.amostra[7] = 10'(a7);
      q.exp_min = 10'(m);
      q.exp_idx = 3'(ix);
      return q;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      compared++;
      if (atual !== esperado) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
      end
   endtask

   // Feeds the 8 samples of q (frame already started) and checks the completion cycle.
   task automatic alimenta(input quadro_t q, input bit gaps, input string nome);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            valido = 1'b0;
            dado   = 10'($urandom_range(0, 1023));
            repeat ($urandom_range(1, 3)) begin
               tick();
               verifica({nome, " gap concluido"}, 32'(concluido), 32'd0);
            end
         end
         verifica({nome, " pronto"}, 32'(pronto), 32'd1);
         valido = 1'b1;
         dado   = q.amostra[i];
         tick();
         valido = 1'b0;
         if (i < 7) verifica({nome, " early concluido"}, 32'(concluido), 32'd0);
      end
      verifica({nome, " concluido"}, 32'(concluido), 32'd1);
      verifica({nome, " menor_valor"}, 32'(menor_valor), 32'(q.exp_min));
      verifica({nome, " indice"}, 32'(indice), 32'(q.exp_idx));
   endtask

   task automatic run_frame(input quadro_t q, input bit gaps, input string nome);
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      verifica({nome, " pronto after start"}, 32'(pronto), 32'd1);
      verifica({nome, " start menor"}, 32'(menor_valor), 32'd1023);
      alimenta(q, gaps, nome);
      tick();
      verifica({nome, " ocupado after"}, 32'(ocupado), 32'd0);
      verifica({nome, " concluido pulse"}, 32'(concluido), 32'd0);
      verifica({nome, " held menor"}, 32'(menor_valor), 32'(q.exp_min));
      verifica({nome, " held indice"}, 32'(indice), 32'(q.exp_idx));
   endtask

   initial begin
      tabela[0] = mk(500, 300, 700, 300, 1023, 12, 12, 900, 12, 5);
      tabela[1] = mk(1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 0);
      tabela[2] = mk(9, 8, 7, 6, 5, 4, 3, 0, 0, 7);
      tabela[3] = mk(40, 41, 42, 43, 44, 45, 46, 47, 40, 0);
      tabela[4] = mk(100, 50, 50, 200, 50, 75, 60, 51, 50, 1);

      // Reset with random inputs
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         iniciar = 1'($urandom_range(0, 1));
         valido  = 1'($urandom_range(0, 1));
         dado    = 10'($urandom_range(0, 1023));
         tick();
      end
      verifica("reset menor", 32'(menor_valor), 32'd1023);
      verifica("reset indice", 32'(indice), 32'd0);
      verifica("reset pronto", 32'(pronto), 32'd0);
      verifica("reset ocupado", 32'(ocupado), 32'd0);
      verifica("reset concluido", 32'(concluido), 32'd0);
      reset = 1'b0; iniciar = 1'b0; valido = 1'b0; dado = '0;
      tick();
      verifica("idle ocupado", 32'(ocupado), 32'd0);

      for (int k = 0; k < 5; k++) run_frame(tabela[k], 1'b0, $sformatf("frame%0d", k));
      run_frame(tabela[0], 1'b1, "gaps0");
      run_frame(tabela[4], 1'b1, "gaps4");

      // valido in OCIOSO must not change anything
      valido = 1'b1;
      dado   = 10'd1;
      repeat (3) tick();
      verifica("idle valido ocupado", 32'(ocupado), 32'd0);
      verifica("idle valido menor", 32'(menor_valor), 32'd50);
      verifica("idle valido indice", 32'(indice), 32'd1);
      valido = 1'b0;

      // Reset after 3 accepted samples aborts the frame
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valido = 1'b1; dado = 10'(5 + i); tick();
      end
      valido = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      verifica("abort ocupado", 32'(ocupado), 32'd0);
      verifica("abort pronto", 32'(pronto), 32'd0);
      verifica("abort menor", 32'(menor_valor), 32'd1023);
      verifica("abort indice", 32'(indice), 32'd0);
      for (int i = 0; i < 6; i++) begin
         valido = 1'b1; dado = 10'd3;
         tick();
         verifica("abort no concluido", 32'(concluido), 32'd0);
      end
      valido = 1'b0;
      run_frame(tabela[3], 1'b0, "post abort");

      // iniciar held through COLETA and FIM: no restart, new frame only from OCIOSO
      iniciar = 1'b1; tick();
      verifica("hold pronto", 32'(pronto), 32'd1);
      alimenta(tabela[2], 1'b0, "hold");
      tick();
      verifica("hold fim ignored", 32'(ocupado), 32'd0);
      verifica("hold result menor", 32'(menor_valor), 32'd0);
      tick();
      verifica("hold restart ocupado", 32'(ocupado), 32'd1);
      verifica("hold restart menor", 32'(menor_valor), 32'd1023);
      iniciar = 1'b0;
      alimenta(tabela[0], 1'b0, "hold second");
      tick();
      verifica("hold second idle", 32'(ocupado), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
